// File: rtl/serial_pkg.sv
// Shared definitions for the parity-framed serial link (transmitter and receiver).
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Parity bit that makes data plus parity hold an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and flags the last cycle of each period.
module bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Restart the period on load, wrap at the end of each period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx_parity.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB-first, odd parity, stop bit.
// Optional build macro SERIAL_TX_PARITY_INJECT_EN adds parity_err_inject, which
// inverts the parity bit of the frame accepted while it is high.
module serial_tx_parity
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 out,
  output logic                 busy
`ifdef SERIAL_TX_PARITY_INJECT_EN
  ,
  input  logic                 parity_err_inject
`endif
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 accept;
  logic                 load;
  logic                 par_next;

`ifdef SERIAL_TX_PARITY_INJECT_EN
  assign par_next = odd_parity(data_in) ^ parity_err_inject;
`else
  assign par_next = odd_parity(data_in);
`endif

  // Ready in idle, and in the final stop cycle so frames can run back to back.
  assign ready  = (state == IDLE) || (state == STOP && tick);
  assign accept = valid && ready;

  // The bit timer restarts whenever the state changes.
  assign load = accept ||
                (tick && (state == START || state == PARITY || state == STOP ||
                          (state == DATA && bit_idx == LAST_BIT)));

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .tick   (tick)
  );

  // Control FSM; out is registered, so each transition loads the level of the next bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      out     <= IDLE_LEVEL;
      busy    <= 1'b0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= START;
            out   <= START_LEVEL;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            out     <= shreg[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              state   <= PARITY;
              out     <= par;
              bit_idx <= '0;
            end else begin
              out     <= shreg[0];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            out   <= IDLE_LEVEL;
          end
        end
        STOP: begin
          if (accept) begin
            state <= START;
            out   <= START_LEVEL;
          end else if (tick) begin
            state <= IDLE;
            out   <= IDLE_LEVEL;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          out   <= IDLE_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Data path: capture byte and parity on accept; shift out one bit per period.
  // shreg[0] always holds the next data bit to put on the line.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= data_in;
      par   <= par_next;
    end else if (tick && (state == START || state == DATA)) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_serial_tx_parity.sv
// Self-checking bench for serial_tx_parity with BIT_CYCLES = 1.
module tb_serial_tx_parity;
  import serial_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       out;
  logic       busy;
`ifdef SERIAL_TX_PARITY_INJECT_EN
  logic       parity_err_inject;
`endif

  int n_tests;
  int n_fail;

  serial_tx_parity #(
    .BIT_CYCLES(1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .valid  (valid),
    .ready  (ready),
    .out    (out),
    .busy   (busy)
`ifdef SERIAL_TX_PARITY_INJECT_EN
    ,
    .parity_err_inject(parity_err_inject)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;   // hand-computed odd parity bit
  } vec_t;

  vec_t vecs [8];

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};  // bit 0 is transmitted first
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Handshake one byte from idle and capture out/busy/ready for the 11 frame cycles.
  task automatic send_capture(input logic [7:0] d, output logic [10:0] o,
                              output logic [10:0] b, output logic [10:0] r);
    @(negedge clk);
    valid   = 1'b1;
    data_in = d;
    @(posedge clk);
    #1;
    valid   = 1'b0;
    data_in = ~d;
    o[0] = out; b[0] = busy; r[0] = ready;
    for (int i = 1; i < 11; i++) begin
      @(posedge clk);
      #1;
      o[i] = out; b[i] = busy; r[i] = ready;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_out"},   64'(out),   64'd1);
    check({name, "_busy"},  64'(busy),  64'd0);
    check({name, "_ready"}, 64'(ready), 64'd1);
  endtask

  logic [10:0] o, b, r;
  logic [21:0] o22, b22;
  logic [32:0] o33;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{8'hA5, 1'b1};
    vecs[1] = '{8'h07, 1'b0};
    vecs[2] = '{8'h00, 1'b1};
    vecs[3] = '{8'hFF, 1'b1};
    vecs[4] = '{8'h3C, 1'b1};
    vecs[5] = '{8'h01, 1'b0};
    vecs[6] = '{8'h80, 1'b0};
    vecs[7] = '{8'h55, 1'b1};

    reset_n = 1'b0;
    valid   = 1'b1;   // must be ignored during reset
    data_in = 8'h00;
`ifdef SERIAL_TX_PARITY_INJECT_EN
    parity_err_inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    valid   = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("after_reset");

    // Table of single frames
    for (int k = 0; k < 8; k++) begin
      send_capture(vecs[k].data, o, b, r);
      check($sformatf("frame_%02h", vecs[k].data), 64'(o), 64'(frame(vecs[k].data, vecs[k].par)));
      check($sformatf("busy_%02h", vecs[k].data), 64'(b), 64'h7FF);
      check($sformatf("ready_%02h", vecs[k].data), 64'(r), 64'h400);
      check_idle($sformatf("idle_%02h", vecs[k].data));
    end

    // Back-to-back: second handshake in the stop cycle of the first frame
    @(negedge clk);
    valid   = 1'b1;
    data_in = 8'h00;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      valid = 1'b0;
      o22[i] = out;
      b22[i] = busy;
      if (i == 10) begin
        check("b2b_ready_stop", 64'(ready), 64'd1);
        valid   = 1'b1;
        data_in = 8'hFF;
      end
    end
    check("b2b_frames", 64'(o22), 64'({frame(8'hFF, 1'b1), frame(8'h00, 1'b1)}));
    check("b2b_busy", 64'(b22), 64'h3FFFFF);
    @(posedge clk);
    #1;
    check_idle("b2b_idle");

    // valid held 30 cycles with data changing every cycle
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      valid   = (k < 30);
      data_in = 8'h10 + 8'(k);
      @(posedge clk);
      #1;
      o33[k] = out;
    end
    check("hold_valid_frames", 64'(o33),
          64'({frame(8'h26, 1'b0), frame(8'h1B, 1'b1), frame(8'h10, 1'b0)}));
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
    check_idle("hold_idle");

    // Reset during data bit 3
    @(negedge clk);
    valid   = 1'b1;
    data_in = 8'h3C;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_bit3_busy", 64'(busy), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    send_capture(8'h96, o, b, r);
    check("post_reset_frame", 64'(o), 64'(frame(8'h96, 1'b1)));
    check("post_reset_busy", 64'(b), 64'h7FF);

`ifdef SERIAL_TX_PARITY_INJECT_EN
    parity_err_inject = 1'b1;
    send_capture(8'h3C, o, b, r);
    parity_err_inject = 1'b0;
    check("inject_frame", 64'(o), 64'(frame(8'h3C, 1'b0)));
    send_capture(8'h3C, o, b, r);
    check("inject_cleared_frame", 64'(o), 64'(frame(8'h3C, 1'b1)));
`endif

    check("frame_length", 64'(FRAME_BITS), 64'd11);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
